// File: rtl/watch_pkg.sv
// Shared definitions for the watch control slice: FSM states, field indices
// and the default cycle counts used by the control unit and its helpers.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EDIT = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // Field indices; o_digit_sel is one-hot on these positions.
  localparam int FLD_MSEC = 0;
  localparam int FLD_SEC  = 1;
  localparam int FLD_MIN  = 2;
  localparam int FLD_HOUR = 3;

  // Default cycle counts at 100 MHz.
  localparam int DEF_HOLD_CYCLES    = 50_000_000;
  localparam int DEF_REPEAT_CYCLES  = 10_000_000;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000_000;
  localparam int DEF_BLINK_CYCLES   = 25_000_000;

endpackage

// File: rtl/watch_ctrl_unit_btn_repeat.sv
// Rising-edge detector with auto-repeat for one debounced button.
// o_pulse is combinational; the owner registers it.
// A pulse fires on the rise, then again HOLD_CYCLES later, then every
// REPEAT_CYCLES while the level stays high. Dropping en or the level
// cancels the sequence; it only restarts on a fresh rise.
module btn_repeat
  import watch_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic i_level,
  output logic o_pulse
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic          level_q, level_d;
  logic          active_q, active_d;
  logic          rep_q, rep_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Edge detect, hold phase, then periodic repeat phase.
  always_comb begin
    level_d  = i_level;
    active_d = active_q;
    rep_d    = rep_q;
    cnt_d    = cnt_q;
    o_pulse  = 1'b0;
    if (!en || !i_level) begin
      active_d = 1'b0;
      rep_d    = 1'b0;
      cnt_d    = '0;
    end else if (!level_q) begin
      o_pulse  = 1'b1;
      active_d = 1'b1;
      rep_d    = 1'b0;
      cnt_d    = '0;
    end else if (active_q) begin
      if (!rep_q) begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          o_pulse = 1'b1;
          rep_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (cnt_q == CW'(REPEAT_CYCLES - 1)) begin
        o_pulse = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q  <= 1'b0;
      active_q <= 1'b0;
      rep_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      level_q  <= level_d;
      active_q <= active_d;
      rep_q    <= rep_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/watch_ctrl_unit.sv
// Watch control FSM: turns debounced buttons/switches into datapath strobes
// (run, mode, clear, field select, up/down) with auto-repeat, edit timeout
// and a blink flag. All outputs are registered. o_dbg_state exposes the FSM.
// Strobes are single-cycle pulses with no handshake: the datapath must act on
// every cycle a strobe is high; there is no back-pressure.
module watch_ctrl_unit
  import watch_pkg::*;
#(
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int BLINK_CYCLES   = DEF_BLINK_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_sw_set,
  input  logic       i_sw_mode,
  input  logic       i_sw_disp,
  input  logic       i_btn_l,
  input  logic       i_btn_r,
  input  logic       i_btn_u,
  input  logic       i_btn_d,
  input  logic       i_btn_c,
  output logic       o_run,
  output logic       o_mode,
  output logic       o_clear,
  output logic [3:0] o_digit_sel,
  output logic       o_time_up,
  output logic       o_time_down,
  output logic       o_sel_disp,
  output logic       o_blink,
  output logic       o_editing,
  output logic [1:0] o_dbg_state
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  // Button vector order: [0]=l [1]=r [2]=u [3]=d [4]=c
  logic [4:0] btn_vec, btn_q, btn_d, rise;
  state_t     state_q, state_d;
  logic [1:0] cursor_q, cursor_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic       blink_q, blink_d;
  logic       up_pulse, dn_pulse, rep_en, activity;
  logic       run_q, run_d, mode_q, mode_d, clear_q, clear_d;
  logic       up_q, up_d, down_q, down_d, sel_disp_q, sel_disp_d, editing_q, editing_d;
  logic [3:0] digit_sel_q, digit_sel_d;

  assign btn_vec = {i_btn_c, i_btn_d, i_btn_u, i_btn_r, i_btn_l};
  assign rise    = btn_vec & ~btn_q;
  // Up/down only act in EDIT and cancel each other when pressed together.
  assign rep_en  = (state_q == ST_EDIT) && !(i_btn_u && i_btn_d);

  btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_rep_up (
    .clk(clk), .reset(reset), .en(rep_en), .i_level(i_btn_u), .o_pulse(up_pulse)
  );
  btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_rep_dn (
    .clk(clk), .reset(reset), .en(rep_en), .i_level(i_btn_d), .o_pulse(dn_pulse)
  );

  assign activity = (|rise) || up_pulse || dn_pulse;

  // Next state, cursor, timeout/blink counters and next registered outputs.
  always_comb begin
    btn_d       = btn_vec;
    state_d     = state_q;
    cursor_d    = cursor_q;
    to_cnt_d    = to_cnt_q;
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_sw_set) begin
          state_d  = ST_EDIT;
          cursor_d = 2'(FLD_MSEC);
          to_cnt_d = '0;
        end
      end
      ST_EDIT: begin
        if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
          blink_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
          blink_d     = blink_q;
        end
        if (rise[0] && !rise[1]) cursor_d = cursor_q + 2'd1;
        if (rise[1] && !rise[0]) cursor_d = cursor_q - 2'd1;
        if (activity) begin
          to_cnt_d = '0;
        end else if (to_cnt_q != TW'(TIMEOUT_CYCLES - 1)) begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
        if (!i_sw_set) begin
          state_d = ST_RUN;
        end else if (!activity && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (!i_sw_set) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    // Blink only runs inside EDIT and restarts from 0 on every entry.
    if (state_d != ST_EDIT) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end
    run_d       = (state_d != ST_EDIT);
    editing_d   = (state_d == ST_EDIT);
    mode_d      = i_sw_mode;
    digit_sel_d = 4'b0001 << cursor_d;
    sel_disp_d  = (state_d == ST_EDIT) ? cursor_d[1] : i_sw_disp;
    clear_d     = (state_q != ST_EDIT) && rise[4];
    up_d        = up_pulse;
    down_d      = dn_pulse;
  end

  // Registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_q       <= '0;
      state_q     <= ST_RUN;
      cursor_q    <= 2'(FLD_MSEC);
      to_cnt_q    <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      run_q       <= 1'b1;
      mode_q      <= 1'b0;
      clear_q     <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      sel_disp_q  <= 1'b0;
      editing_q   <= 1'b0;
      digit_sel_q <= 4'b0001;
    end else begin
      btn_q       <= btn_d;
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      run_q       <= run_d;
      mode_q      <= mode_d;
      clear_q     <= clear_d;
      up_q        <= up_d;
      down_q      <= down_d;
      sel_disp_q  <= sel_disp_d;
      editing_q   <= editing_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign o_run       = run_q;
  assign o_mode      = mode_q;
  assign o_clear     = clear_q;
  assign o_digit_sel = digit_sel_q;
  assign o_time_up   = up_q;
  assign o_time_down = down_q;
  assign o_sel_disp  = sel_disp_q;
  assign o_blink     = blink_q;
  assign o_editing   = editing_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_watch_ctrl_unit.sv
// Bench for watch_ctrl_unit with short cycle counts. Strobe events are
// expected as {type, cycle} words in a queue; a negedge monitor pops and
// compares whenever a strobe is seen. Level outputs are checked directly.
module tb_watch_ctrl_unit;
  import watch_pkg::*;

  localparam int L = 0, R = 1, U = 2, D = 3, C = 4;
  localparam logic [1:0] EV_CLR = 2'd1, EV_UP = 2'd2, EV_DN = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_set, sw_mode, sw_disp;
  logic [4:0] btn;
  logic       o_run, o_mode, o_clear, o_time_up, o_time_down;
  logic       o_sel_disp, o_blink, o_editing;
  logic [3:0] o_digit_sel;
  logic [1:0] o_dbg_state;

  logic [29:0] cyc = '0;
  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 30'd1;

  watch_ctrl_unit #(
    .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .TIMEOUT_CYCLES(40), .BLINK_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset),
    .i_sw_set(sw_set), .i_sw_mode(sw_mode), .i_sw_disp(sw_disp),
    .i_btn_l(btn[L]), .i_btn_r(btn[R]), .i_btn_u(btn[U]),
    .i_btn_d(btn[D]), .i_btn_c(btn[C]),
    .o_run(o_run), .o_mode(o_mode), .o_clear(o_clear),
    .o_digit_sel(o_digit_sel), .o_time_up(o_time_up), .o_time_down(o_time_down),
    .o_sel_disp(o_sel_disp), .o_blink(o_blink), .o_editing(o_editing),
    .o_dbg_state(o_dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic [1:0] t, input logic [29:0] c);
    exp_q.push_back({t, c});
  endtask

  task automatic mon_pop(input logic [31:0] act);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL strobe_unexpected: got type %0d at cycle %0d, none expected",
               act[31:30], act[29:0]);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        bad++;
        $display("FAIL strobe: got type %0d at cycle %0d, expected type %0d at cycle %0d",
                 act[31:30], act[29:0], e[31:30], e[29:0]);
      end
    end
  endtask

  // Monitor: every strobe the DUT shows must match the head of the queue.
  always @(negedge clk) begin
    if (o_clear)     mon_pop({EV_CLR, cyc});
    if (o_time_up)   mon_pop({EV_UP, cyc});
    if (o_time_down) mon_pop({EV_DN, cyc});
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive button idx high for 'hold' cycles; called and returns at a negedge.
  task automatic press(input int idx, input int hold);
    btn[idx] = 1'b1;
    wait_cyc(hold);
    btn[idx] = 1'b0;
  endtask

  initial begin
    logic [3:0] l_seq[5];
    logic [29:0] n;
    l_seq[0] = 4'b0010; l_seq[1] = 4'b0100; l_seq[2] = 4'b1000;
    l_seq[3] = 4'b0001; l_seq[4] = 4'b0010;

    reset = 1'b0; sw_set = 1'b0; sw_mode = 1'b0; sw_disp = 1'b0; btn = '0;

    // 1: reset values, then unchanged after release
    wait_cyc(3);
    chk("rst_run", 32'(o_run), 32'd1);
    chk("rst_digit_sel", 32'(o_digit_sel), 32'b0001);
    chk("rst_strobes", 32'({o_clear, o_time_up, o_time_down}), 32'd0);
    chk("rst_blink_edit", 32'({o_blink, o_editing}), 32'd0);
    reset = 1'b1;
    wait_cyc(2);
    chk("post_rst_run", 32'(o_run), 32'd1);
    chk("post_rst_digit_sel", 32'(o_digit_sel), 32'b0001);
    chk("post_rst_state", 32'(o_dbg_state), 32'(ST_RUN));

    // RUN: mode and display page follow the switches
    sw_mode = 1'b1; sw_disp = 1'b1;
    wait_cyc(2);
    chk("run_mode", 32'(o_mode), 32'd1);
    chk("run_sel_disp", 32'(o_sel_disp), 32'd1);
    sw_mode = 1'b0; sw_disp = 1'b0;
    wait_cyc(2);
    chk("run_sel_disp_low", 32'(o_sel_disp), 32'd0);

    // 2: clear held 10 clk -> one pulse at rise+1
    expect_ev(EV_CLR, cyc + 30'd1);
    press(C, 10);
    wait_cyc(3);

    // 3: enter EDIT, walk the cursor
    sw_set = 1'b1;
    wait_cyc(2);
    chk("edit_editing", 32'(o_editing), 32'd1);
    chk("edit_run", 32'(o_run), 32'd0);
    chk("edit_digit_sel0", 32'(o_digit_sel), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      press(L, 1);
      wait_cyc(1);
      chk($sformatf("btn_l_%0d", i), 32'(o_digit_sel), 32'(l_seq[i]));
      if (i == 2) chk("sel_disp_cur3", 32'(o_sel_disp), 32'd1);
    end
    press(R, 1); wait_cyc(1);
    chk("btn_r_0", 32'(o_digit_sel), 32'b0001);
    chk("sel_disp_cur0", 32'(o_sel_disp), 32'd0);
    press(R, 1); wait_cyc(1);
    chk("btn_r_1", 32'(o_digit_sel), 32'b1000);
    chk("sel_disp_cur3b", 32'(o_sel_disp), 32'd1);
    btn[L] = 1'b1; btn[R] = 1'b1;
    wait_cyc(1);
    btn[L] = 1'b0; btn[R] = 1'b0;
    wait_cyc(1);
    chk("btn_lr_nomove", 32'(o_digit_sel), 32'b1000);

    // 4: auto-repeat on held up
    n = cyc;
    expect_ev(EV_UP, n + 30'd1);
    expect_ev(EV_UP, n + 30'd9);
    expect_ev(EV_UP, n + 30'd13);
    expect_ev(EV_UP, n + 30'd17);
    press(U, 20);
    wait_cyc(2);
    // up and down together: no strobe even past the hold time
    btn[U] = 1'b1; btn[D] = 1'b1;
    wait_cyc(12);
    btn[U] = 1'b0; btn[D] = 1'b0;
    wait_cyc(2);
    // clear ignored in EDIT
    press(C, 2);
    wait_cyc(2);
    // single down press
    expect_ev(EV_DN, cyc + 30'd1);
    press(D, 2);
    wait_cyc(2);

    // 5: timeout to LOCK, counted from a button rise at n+1
    n = cyc;
    press(C, 1);
    while (cyc != n + 30'd40) @(negedge clk);
    chk("timeout_edge_minus1", 32'(o_dbg_state), 32'(ST_EDIT));
    wait_cyc(1);
    chk("timeout_lock", 32'(o_dbg_state), 32'(ST_LOCK));
    chk("lock_run", 32'(o_run), 32'd1);
    chk("lock_editing", 32'(o_editing), 32'd0);
    wait_cyc(5);
    chk("lock_stays", 32'(o_dbg_state), 32'(ST_LOCK));
    expect_ev(EV_CLR, cyc + 30'd1);
    press(C, 2);
    wait_cyc(2);
    sw_set = 1'b0;
    wait_cyc(2);
    chk("lock_to_run", 32'(o_dbg_state), 32'(ST_RUN));
    n = cyc;
    sw_set = 1'b1;
    wait_cyc(5);
    chk("reenter_edit", 32'(o_dbg_state), 32'(ST_EDIT));
    chk("blink_lo_a", 32'(o_blink), 32'd0);
    wait_cyc(1);
    chk("blink_hi", 32'(o_blink), 32'd1);
    wait_cyc(5);
    chk("blink_lo_b", 32'(o_blink), 32'd0);
    chk("reenter_cursor", 32'(o_digit_sel), 32'b0001);

    // 6: reset in the middle of auto-repeat
    n = cyc;
    expect_ev(EV_UP, n + 30'd1);
    expect_ev(EV_UP, n + 30'd9);
    btn[U] = 1'b1;
    wait_cyc(11);
    reset = 1'b0; btn[U] = 1'b0; sw_set = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(20);
    chk("rst_mid_state", 32'(o_dbg_state), 32'(ST_RUN));
    chk("rst_mid_digit_sel", 32'(o_digit_sel), 32'b0001);
    chk("rst_mid_run", 32'(o_run), 32'd1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
